pwm_controller: RTL
===================

PWM_CONTROLLER -- requirements
Module: pwm_controller

Interface
REQ-001 SHALL have parameter CLK_DIV, default 3000, meaning system clocks per PWM tick (legal range 1 to 65535).
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port en_out  input  16  per-channel output enable, taken from the SPI register bank.
REQ-005 SHALL have port en_pwm_mode  input  16  per-channel mode select: 1 = PWM, 0 = static high.
REQ-006 SHALL have port pwm_duty  input  8  shared duty value; output high count = pwm_duty ticks out of 256.
REQ-007 SHALL have port cfg_update  input  1  one-cycle strobe raised when an SPI register write completes.
REQ-008 SHALL have port pwm_out  output  16  registered channel outputs.
REQ-009 SHALL have port period_start  output  1  one-cycle pulse when the PWM counter wraps to 0.
REQ-010 SHALL have port cfg_pending  output  1  high while an accepted configuration update waits for the period boundary.

Function
REQ-011 SHALL implement a 16-bit prescaler counting 0 to CLK_DIV-1; tick is asserted in the cycle where prescaler = CLK_DIV-1, then the prescaler returns to 0.
REQ-012 SHALL implement an 8-bit pwm_cnt that increments on each tick and wraps from 255 to 0.
REQ-013 SHALL run an FSM with states IDLE and RUN, decoded from the active configuration (live inputs or shadow registers, per REQ-024/025): IDLE when (active en_out & active en_pwm_mode) = 0; otherwise RUN.
REQ-014 In IDLE, SHALL hold the prescaler and pwm_cnt at 0.
REQ-015 SHALL move IDLE to RUN in the cycle after a PWM-mode channel becomes active; counting starts from pwm_cnt = 0, with period_start pulsing on that entry.
REQ-016 SHALL move RUN to IDLE immediately when no active channel remains in PWM mode.
REQ-017 SHALL compute channel i as: 0 if en_out[i]=0; 1 if en_pwm_mode[i]=0; 1 if duty=255; otherwise (pwm_cnt < duty), using active values.
REQ-018 Duty boundaries: duty=0 gives a constant low output; duty=255 gives a constant high output.
REQ-019 SHALL register pwm_out, so an output reflects the counter and configuration one clk cycle after they change.
REQ-020 SHALL pulse period_start for exactly one cycle on each 255 to 0 wrap of pwm_cnt.

Reset
REQ-021 On rst_n low, SHALL immediately clear prescaler, pwm_cnt, pwm_out, period_start, cfg_pending and all shadow registers, and set the FSM to IDLE.
REQ-022 Reset asserted mid-period SHALL discard any pending update.
REQ-023 After reset deassertion, SHALL resume in IDLE.

Configuration
REQ-024 With PWM_SHADOW_EN defined:
- on cfg_update, en_out, en_pwm_mode and pwm_duty SHALL be captured into a staging register set;
- staged values SHALL become active only at the next wrap in RUN, or in the next cycle when in IDLE;
- cfg_pending SHALL be high from the cycle after an update is staged in RUN until the cycle after it is applied;
- a second cfg_update before the boundary SHALL overwrite the staged set;
- cfg_update coincident with a wrap SHALL apply the new values at that wrap.
REQ-025 Without PWM_SHADOW_EN:
- active values SHALL equal the live inputs every cycle;
- cfg_update SHALL be ignored;
- cfg_pending SHALL be tied 0.

Structure
REQ-026 Package pwm_pkg SHALL hold NUM_CH=16, PWM_W=8, the FSM state encoding (IDLE, RUN) and the default CLK_DIV.
REQ-027 The prescaler SHALL be a sub-module named pwm_prescaler (inputs: enable, clear; output: tick).
REQ-028 The FSM, counter, shadow set and output stage SHALL reside in pwm_controller.

Verification (CLK_DIV=4)
REQ-029 en_out=0x0001, mode=0x0001, duty=128 -> pwm_out[0] high for 512 clks, low for 512; period_start every 1024 clks.
REQ-030 duty=0 then duty=255 with channel 0 in PWM mode -> constant 0, then constant 1; other channels stay 0.
REQ-031 en_out=0x8000, mode=0x0000 -> pwm_out[15]=1 one cycle after the input change; FSM stays IDLE; pwm_cnt stays 0.
REQ-032 PWM_SHADOW_EN: duty 64 to 192 via cfg_update at pwm_cnt=10 -> old duty holds to wrap, new duty applies from the next period; cfg_pending high until then.
REQ-033 rst_n pulsed at pwm_cnt=100 with an update pending -> all outputs 0 at once; after release, staged value is not applied.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths, FSM encoding and default prescaler ratio for the PWM controller
package pwm_pkg;
  localparam int NUM_CH      = 16;
  localparam int PWM_W       = 8;
  localparam int DEF_CLK_DIV = 3000;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;
endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: divides clk down to a one-cycle tick every CLK_DIV cycles while enabled
module pwm_prescaler import pwm_pkg::*; #(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);
  localparam logic [15:0] LAST = 16'(CLK_DIV - 1);
  logic [15:0] cnt_q, cnt_d;
  // Tick on the last count, then wrap; clear dominates and parks the count at 0
  always_comb begin
    tick  = enable && !clear && cnt_q == LAST;
    cnt_d = clear ? '0 : !enable ? cnt_q : tick ? '0 : cnt_q + 16'd1;
  end
  // Prescaler count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/pwm_controller.sv
// pwm_controller: 16-channel shared-duty PWM; define PWM_SHADOW_EN to stage config until the period boundary
module pwm_controller import pwm_pkg::*; #(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en_out,
  input  logic [NUM_CH-1:0] en_pwm_mode,
  input  logic [PWM_W-1:0]  pwm_duty,
  input  logic              cfg_update,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_start,
  output logic              cfg_pending
);
  state_e            state_q, state_d;
  logic [PWM_W-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic              ps_q, ps_d;
  logic [NUM_CH-1:0] act_en, act_mode;
  logic [PWM_W-1:0]  act_duty;
  logic              pwm_any, run, tick, wrap;

  assign pwm_any = |(act_en & act_mode);
  // Counting stops in the same cycle the last PWM channel goes away, without waiting for the FSM
  assign run     = state_q == RUN && pwm_any;
  assign wrap    = tick && cnt_q == '1;

  pwm_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
    .clk(clk),
    .rst_n(rst_n),
    .enable(run),
    .clear(!run),
    .tick(tick)
  );

`ifdef PWM_SHADOW_EN
  logic [NUM_CH-1:0] act_en_q, act_en_d, act_mode_q, act_mode_d;
  logic [NUM_CH-1:0] stg_en_q, stg_en_d, stg_mode_q, stg_mode_d;
  logic [PWM_W-1:0]  act_duty_q, act_duty_d, stg_duty_q, stg_duty_d;
  logic              pend_q, pend_d, boundary, take_live, take_stg;

  assign boundary  = state_q == IDLE || wrap;
  assign take_live = cfg_update && boundary;
  assign take_stg  = pend_q && boundary && !cfg_update;
  // An update at a boundary goes straight to the active set; otherwise it is staged until the next wrap
  always_comb begin
    stg_en_d   = cfg_update ? en_out : stg_en_q;
    stg_mode_d = cfg_update ? en_pwm_mode : stg_mode_q;
    stg_duty_d = cfg_update ? pwm_duty : stg_duty_q;
    pend_d     = !boundary && (cfg_update || pend_q);
    act_en_d   = take_live ? en_out : take_stg ? stg_en_q : act_en_q;
    act_mode_d = take_live ? en_pwm_mode : take_stg ? stg_mode_q : act_mode_q;
    act_duty_d = take_live ? pwm_duty : take_stg ? stg_duty_q : act_duty_q;
  end
  // Staging and active configuration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_en_q   <= '0;
      stg_mode_q <= '0;
      stg_duty_q <= '0;
      act_en_q   <= '0;
      act_mode_q <= '0;
      act_duty_q <= '0;
      pend_q     <= 1'b0;
    end else begin
      stg_en_q   <= stg_en_d;
      stg_mode_q <= stg_mode_d;
      stg_duty_q <= stg_duty_d;
      act_en_q   <= act_en_d;
      act_mode_q <= act_mode_d;
      act_duty_q <= act_duty_d;
      pend_q     <= pend_d;
    end
  end
  assign act_en      = act_en_q;
  assign act_mode    = act_mode_q;
  assign act_duty    = act_duty_q;
  assign cfg_pending = pend_q;
`else
  logic unused_cfg_update;
  assign unused_cfg_update = cfg_update;
  assign act_en            = en_out;
  assign act_mode          = en_pwm_mode;
  assign act_duty          = pwm_duty;
  assign cfg_pending       = 1'b0;
`endif

  // Next state, period counter, period marker and per-channel output decode
  always_comb begin
    state_d = pwm_any ? RUN : IDLE;
    cnt_d   = !run ? '0 : tick ? cnt_q + PWM_W'(1) : cnt_q;
    ps_d    = (state_q == IDLE && pwm_any) || wrap;
    for (int i = 0; i < NUM_CH; i++)
      pwm_d[i] = !act_en[i] ? 1'b0 : (!act_mode[i] || act_duty == '1) ? 1'b1 : cnt_q < act_duty;
  end
  // FSM, counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pwm_q   <= '0;
      ps_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pwm_q   <= pwm_d;
      ps_q    <= ps_d;
    end
  end
  assign pwm_out      = pwm_q;
  assign period_start = ps_q;
endmodule
